// File: rtl/decode_queue.sv
// decode_queue: multi-slot decode stage feeding a circular buffer between fetch and issue.
// Optional DECODE_DELAY_SLOT_PAIR_EN: a branch/jump is never presented without its delay slot.

package decode_queue_pkg;
  typedef enum logic [4:0] {
    OP_RESERVED, OP_SLL, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_JR, OP_ADDIU, OP_ANDI,
    OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_MFC0, OP_MTC0, OP_COP
  } op_e;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic [3:0] ce;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
  } ctl_t;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] target;
    ctl_t        ctl;
    logic        exception_ri;
    logic        exception_cpu;
  } decoded_instr_t;

  localparam int DI_W = $bits(decoded_instr_t);
endpackage

module decoder
  import decode_queue_pkg::*;
(
  input  logic [31:0]    instr,
  input  logic [31:0]    pcplus4,
  input  logic           is_usermode,
  input  logic [3:0]     cu,
  output decoded_instr_t dec
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [1:0]  cop_n;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];
  assign cop_n  = instr[27:26];

  always_comb begin
    dec        = '0;
    dec.op     = OP_RESERVED;
    dec.rs     = instr[25:21];
    dec.rt     = instr[20:16];
    dec.rd     = instr[15:11];
    dec.imm    = {{16{imm16[15]}}, imm16};
    case (opcode)
      6'h00: begin
        dec.ctl.reg_wr = 1'b1;
        case (funct)
          6'h00: dec.op = OP_SLL;
          6'h08: begin
            dec.op         = OP_JR;
            dec.ctl.jump   = 1'b1;
            dec.ctl.reg_wr = 1'b0;
          end
          6'h21: dec.op = OP_ADDU;
          6'h23: dec.op = OP_SUBU;
          6'h24: dec.op = OP_AND;
          6'h25: dec.op = OP_OR;
          default: dec.ctl.reg_wr = 1'b0;
        endcase
      end
      6'h02, 6'h03: begin
        dec.op         = opcode[0] ? OP_JAL : OP_J;
        dec.ctl.jump   = 1'b1;
        dec.ctl.reg_wr = opcode[0];
        if (opcode[0]) dec.rd = 5'd31;
        dec.target     = {pcplus4[31:28], instr[25:0], 2'b00};
      end
      6'h04, 6'h05: begin
        dec.op         = opcode[0] ? OP_BNE : OP_BEQ;
        dec.ctl.branch = 1'b1;
        dec.target     = pcplus4 + {dec.imm[29:0], 2'b00};
      end
      6'h09: begin dec.op = OP_ADDIU; dec.ctl.reg_wr = 1'b1; end
      6'h0C: begin dec.op = OP_ANDI; dec.ctl.reg_wr = 1'b1; dec.imm = {16'h0, imm16}; end
      6'h0D: begin dec.op = OP_ORI; dec.ctl.reg_wr = 1'b1; dec.imm = {16'h0, imm16}; end
      6'h0F: begin dec.op = OP_LUI; dec.ctl.reg_wr = 1'b1; dec.imm = {imm16, 16'h0}; end
      6'h23: begin dec.op = OP_LW; dec.ctl.reg_wr = 1'b1; dec.ctl.mem_rd = 1'b1; end
      6'h2B: begin dec.op = OP_SW; dec.ctl.mem_wr = 1'b1; end
      6'h10, 6'h11, 6'h12, 6'h13: begin
        dec.ctl.ce[cop_n] = 1'b1;
        if (cop_n == 2'd0) begin
          // CP0 is always usable in kernel mode; user mode needs CU0.
          dec.exception_cpu = is_usermode & ~cu[0];
          if (dec.rs == 5'd0) begin
            dec.op         = OP_MFC0;
            dec.ctl.reg_wr = 1'b1;
          end else if (dec.rs == 5'd4) begin
            dec.op = OP_MTC0;
          end
        end else begin
          dec.op            = OP_COP;
          dec.exception_cpu = ~cu[cop_n];
        end
      end
      default: ;
    endcase
    dec.exception_ri = (dec.op == OP_RESERVED);
  end
endmodule

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] in_count,
  input  logic [FETCH_WIDTH*32-1:0]        in_instr,
  input  logic [FETCH_WIDTH*32-1:0]        in_pc,
  output logic                             in_ready,
  input  logic                             is_usermode,
  input  logic [3:0]                       cu,
  output logic [$clog2(ISSUE_WIDTH+1)-1:0] out_count,
  output logic [ISSUE_WIDTH*DI_W-1:0]      out_instr,
  output logic [ISSUE_WIDTH*32-1:0]        out_pc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0] issue_count,
  input  logic                             flush
);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);
  localparam int ICW = $clog2(FETCH_WIDTH + 1);
  localparam int OCW = $clog2(ISSUE_WIDTH + 1);

  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]  count_q, count_d;
  decoded_instr_t mem_instr_q [DEPTH];
  decoded_instr_t mem_instr_d [DEPTH];
  logic [31:0]    mem_pc_q [DEPTH];
  logic [31:0]    mem_pc_d [DEPTH];
  decoded_instr_t dec [FETCH_WIDTH];
  logic           enq;
  logic [OCW-1:0] oc_raw;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_dec
    decoder u_dec (
      .instr      (in_instr[i*32 +: 32]),
      .pcplus4    (in_pc[i*32 +: 32] + 32'd4),
      .is_usermode(is_usermode),
      .cu         (cu),
      .dec        (dec[i])
    );
  end

  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(FETCH_WIDTH);
  assign enq      = in_valid && in_ready && !flush;
  assign oc_raw   = (count_q >= CW'(ISSUE_WIDTH)) ? OCW'(ISSUE_WIDTH) : OCW'(count_q);

`ifdef DECODE_DELAY_SLOT_PAIR_EN
  logic [PW-1:0] last_idx;
  logic          last_brj;
  assign last_idx = head_q + PW'(oc_raw - OCW'(1));
  assign last_brj = mem_instr_q[last_idx].ctl.branch | mem_instr_q[last_idx].ctl.jump;
`endif

  always_comb begin
    out_count = oc_raw;
`ifdef DECODE_DELAY_SLOT_PAIR_EN
    // The delay slot of the last presented entry is never itself presented, so hold the branch back.
    if (ISSUE_WIDTH > 1 && oc_raw != '0 && last_brj) out_count = oc_raw - OCW'(1);
`endif
    out_instr = '0;
    out_pc    = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (OCW'(k) < out_count) begin
        out_instr[k*DI_W +: DI_W] = mem_instr_q[head_q + PW'(k)];
        out_pc[k*32 +: 32]        = mem_pc_q[head_q + PW'(k)];
      end
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_instr_d = mem_instr_q;
    mem_pc_d    = mem_pc_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (ICW'(i) < in_count) begin
            mem_instr_d[tail_q + PW'(i)] = dec[i];
            mem_pc_d[tail_q + PW'(i)]    = in_pc[i*32 +: 32];
          end
        end
        tail_d = tail_q + PW'(in_count);
      end
      head_d  = head_q + PW'(issue_count);
      count_d = count_q + (enq ? CW'(in_count) : CW'(0)) - CW'(issue_count);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_instr_q <= mem_instr_d;
    mem_pc_q    <= mem_pc_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (issue_count <= out_count);
  end
endmodule
